game_controller: RTL

- Round/score controller for the two-player code game.
- Produces the game status consumed by the display block:
  - state_f: FSM state.
  - premio_f: round/game winner.
  - p1_f, p2_f: scores.
- Rounds work as follows:
  - The setter enters a 4-bit secret code on the switches.
  - The guesser has MAX_TRIES attempts to match it.
  - Roles swap every round.
  - The game ends when a player reaches WIN_SCORE.

---
 rtl/game_controller_if.sv | 23 ++
 rtl/game_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/game_controller_if.sv
// Game controller bus: player buttons and code switches in, game status out.
// The master modport drives the buttons; the slave modport is the controller.
interface game_controller_if;
  logic       btn_start;
  logic       btn_confirm;
  logic [3:0] sw_code;
  logic [3:0] state_f;
  logic [1:0] premio_f;
  logic [3:0] p1_f;
  logic [3:0] p2_f;
  logic [3:0] tries_f;
  logic       setter_f;

  modport master (
    output btn_start, btn_confirm, sw_code,
    input  state_f, premio_f, p1_f, p2_f, tries_f, setter_f
  );

  modport slave (
    input  btn_start, btn_confirm, sw_code,
    output state_f, premio_f, p1_f, p2_f, tries_f, setter_f
  );
endinterface

// File: rtl/game_controller.sv
// Round/score controller for the two-player code game: synchronizes the
// buttons and switches, runs rounds with role swaps, and keeps the scores.
module game_controller #(
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned WIN_SCORE    = 2,
  parameter int unsigned ROUND_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  game_controller_if.slave  bus
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SET       = 4'd1,
    ST_GUESS     = 4'd2,
    ST_ROUND_END = 4'd3,
    ST_GAME_OVER = 4'd4
  } state_t;

  localparam int unsigned   TW         = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(ROUND_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [3:0]    TRIES_INIT = 4'(MAX_TRIES);
  localparam logic [3:0]    WIN_MAX    = 4'(WIN_SCORE);

  // Bit 0 is the first synchronizer stage; bit 2 delays the second for edge detection.
  logic [2:0]    r_start_sync;
  logic [2:0]    r_confirm_sync;
  logic [3:0]    r_sw_s1;
  logic [3:0]    r_sw_s2;

  state_t        r_state;
  logic [1:0]    r_premio;
  logic [3:0]    r_p1;
  logic [3:0]    r_p2;
  logic [3:0]    r_tries;
  logic          r_setter;
  logic [3:0]    r_secret;
  logic [TW-1:0] r_timer;

  state_t        w_state_nxt;
  logic [1:0]    w_premio_nxt;
  logic [3:0]    w_p1_nxt;
  logic [3:0]    w_p2_nxt;
  logic [3:0]    w_tries_nxt;
  logic          w_setter_nxt;
  logic [3:0]    w_secret_nxt;
  logic [TW-1:0] w_timer_nxt;

  logic          w_start_evt;
  logic          w_confirm_evt;
  logic [3:0]    w_winner_score;

  function automatic logic [3:0] sat_inc(input logic [3:0] score);
    return (score >= WIN_MAX) ? score : score + 4'd1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs; blocking here would let one stage race through the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_sync   <= '0;
      r_confirm_sync <= '0;
      r_sw_s1        <= '0;
      r_sw_s2        <= '0;
    end else begin
      r_start_sync   <= {r_start_sync[1:0], bus.btn_start};
      r_confirm_sync <= {r_confirm_sync[1:0], bus.btn_confirm};
      r_sw_s1        <= bus.sw_code;
      r_sw_s2        <= r_sw_s1;
    end
  end

  assign w_start_evt    = r_start_sync[1] & ~r_start_sync[2];
  assign w_confirm_evt  = r_confirm_sync[1] & ~r_confirm_sync[2];
  assign w_winner_score = (r_premio == 2'b01) ? r_p1 : r_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_premio <= '0;
      r_p1     <= '0;
      r_p2     <= '0;
      r_tries  <= '0;
      r_setter <= 1'b0;
      r_secret <= '0;
      r_timer  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_premio <= w_premio_nxt;
      r_p1     <= w_p1_nxt;
      r_p2     <= w_p2_nxt;
      r_tries  <= w_tries_nxt;
      r_setter <= w_setter_nxt;
      r_secret <= w_secret_nxt;
      r_timer  <= w_timer_nxt;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_premio_nxt = r_premio;
    w_p1_nxt     = r_p1;
    w_p2_nxt     = r_p2;
    w_tries_nxt  = r_tries;
    w_setter_nxt = r_setter;
    w_secret_nxt = r_secret;
    w_timer_nxt  = r_timer;

    case (r_state)
      ST_IDLE: begin
        if (w_start_evt) begin
          w_state_nxt  = ST_SET;
          w_p1_nxt     = '0;
          w_p2_nxt     = '0;
          w_setter_nxt = 1'b0;
        end
      end

      ST_SET: begin
        if (w_confirm_evt) begin
          w_secret_nxt = r_sw_s2;
          w_tries_nxt  = TRIES_INIT;
          w_state_nxt  = ST_GUESS;
        end
      end

      ST_GUESS: begin
        if (w_confirm_evt) begin
          if (r_sw_s2 == r_secret) begin
            // Guesser is player 2 while player 1 sets, and vice versa.
            if (!r_setter) begin
              w_p2_nxt     = sat_inc(r_p2);
              w_premio_nxt = 2'b10;
            end else begin
              w_p1_nxt     = sat_inc(r_p1);
              w_premio_nxt = 2'b01;
            end
            w_timer_nxt = '0;
            w_state_nxt = ST_ROUND_END;
          end else if (r_tries <= 4'd1) begin
            if (!r_setter) begin
              w_p1_nxt     = sat_inc(r_p1);
              w_premio_nxt = 2'b01;
            end else begin
              w_p2_nxt     = sat_inc(r_p2);
              w_premio_nxt = 2'b10;
            end
            w_tries_nxt = '0;
            w_timer_nxt = '0;
            w_state_nxt = ST_ROUND_END;
          end else begin
            w_tries_nxt = r_tries - 4'd1;
          end
        end
      end

      ST_ROUND_END: begin
        if (r_timer == TIMER_LAST) begin
          if (w_winner_score == WIN_MAX) begin
            w_state_nxt = ST_GAME_OVER;
          end else begin
            w_state_nxt  = ST_SET;
            w_setter_nxt = ~r_setter;
            w_premio_nxt = 2'b00;
          end
        end else begin
          w_timer_nxt = r_timer + TIMER_ONE;
        end
      end

      ST_GAME_OVER: begin
        if (w_start_evt) begin
          w_state_nxt  = ST_SET;
          w_p1_nxt     = '0;
          w_p2_nxt     = '0;
          w_premio_nxt = 2'b00;
          w_setter_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_premio_nxt = 2'b00;
      end
    endcase
  end

  assign bus.state_f  = r_state;
  assign bus.premio_f = r_premio;
  assign bus.p1_f     = r_p1;
  assign bus.p2_f     = r_p2;
  assign bus.tries_f  = r_tries;
  assign bus.setter_f = r_setter;

endmodule
